// File: rtl/pmem_arbiter.sv
// Two-requester (I/D) cacheline arbiter in front of a single memory port.
// Optional ARB_ROUND_ROBIN_EN: alternate winners on contention, else D wins.
module pmem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         imem_read,
  input  logic         imem_write,
  input  logic [31:0]  imem_address,
  input  logic [255:0] imem_wdata,
  output logic [255:0] imem_rdata,
  output logic         imem_resp,
  input  logic         dmem_read,
  input  logic         dmem_write,
  input  logic [31:0]  dmem_address,
  input  logic [255:0] dmem_wdata,
  output logic [255:0] dmem_rdata,
  output logic         dmem_resp,
  output logic         mmem_read,
  output logic         mmem_write,
  output logic [31:0]  mmem_address,
  output logic [255:0] mmem_wdata,
  input  logic [255:0] mmem_rdata,
  input  logic         mmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic         ireq;
  logic         dreq;
  logic         grant_i;
  logic         grant_d;
  logic         op_write;
  logic [255:0] i_line;
  logic [255:0] d_line;

  assign ireq = imem_read | imem_write;
  assign dreq = dmem_read | dmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_i;

  assign grant_d = dreq & (~ireq | last_i);

  always_ff @(posedge clk) begin
    if (rst)
      last_i <= 1'b1;
    else if (state == IDLE && (grant_i | grant_d))
      last_i <= grant_i;
  end
`else
  assign grant_d = dreq;
`endif

  assign grant_i = ireq & ~grant_d;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_d)
          state_nx = SERVE_D;
        else if (grant_i)
          state_nx = SERVE_I;
      end
      SERVE_I,
      SERVE_D: begin
        if (mmem_resp)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Responses are gated by rst so an aborted transfer never completes.
  always_comb begin
    mmem_read  = 1'b0;
    mmem_write = 1'b0;
    imem_resp  = 1'b0;
    dmem_resp  = 1'b0;
    case (state)
      SERVE_I: begin
        mmem_read  = ~op_write;
        mmem_write = op_write;
        imem_resp  = mmem_resp & ~rst;
      end
      SERVE_D: begin
        mmem_read  = ~op_write;
        mmem_write = op_write;
        dmem_resp  = mmem_resp & ~rst;
      end
      default: ;
    endcase
    imem_rdata = imem_resp ? mmem_rdata : i_line;
    dmem_rdata = dmem_resp ? mmem_rdata : d_line;
  end

  // Write wins when a requester raises read and write together.
  always_ff @(posedge clk) begin
    if (rst) begin
      mmem_address <= '0;
      mmem_wdata   <= '0;
      op_write     <= 1'b0;
    end else if (state == IDLE && grant_d) begin
      mmem_address <= dmem_address;
      mmem_wdata   <= dmem_wdata;
      op_write     <= dmem_write;
    end else if (state == IDLE && grant_i) begin
      mmem_address <= imem_address;
      mmem_wdata   <= imem_wdata;
      op_write     <= imem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_line <= '0;
      d_line <= '0;
    end else begin
      if (imem_resp)
        i_line <= mmem_rdata;
      if (dmem_resp)
        d_line <= mmem_rdata;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: single I/D transfers, input isolation,
// contention order, reset abort and back-to-back re-grant timing.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_read;
  logic         imem_write;
  logic [31:0]  imem_address;
  logic [255:0] imem_wdata;
  logic [255:0] imem_rdata;
  logic         imem_resp;
  logic         dmem_read;
  logic         dmem_write;
  logic [31:0]  dmem_address;
  logic [255:0] dmem_wdata;
  logic [255:0] dmem_rdata;
  logic         dmem_resp;
  logic         mmem_read;
  logic         mmem_write;
  logic [31:0]  mmem_address;
  logic [255:0] mmem_wdata;
  logic [255:0] mmem_rdata;
  logic         mmem_resp;

  int passed = 0;
  int total  = 0;

  pmem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_write   (imem_write),
    .imem_address (imem_address),
    .imem_wdata   (imem_wdata),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .mmem_read    (mmem_read),
    .mmem_write   (mmem_write),
    .mmem_address (mmem_address),
    .mmem_wdata   (mmem_wdata),
    .mmem_rdata   (mmem_rdata),
    .mmem_resp    (mmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic respond(input logic [255:0] line);
    mmem_rdata = line;
    mmem_resp  = 1'b1;
    #1;
  endtask

  task automatic release_resp;
    mmem_resp  = 1'b0;
    mmem_rdata = {8{32'hbad0bad0}};
    #1;
  endtask

  localparam logic [255:0] L1 = {8{32'h1111_aaaa}};
  localparam logic [255:0] L2 = {8{32'h2222_bbbb}};
  localparam logic [255:0] L3 = {8{32'h3333_cccc}};
  localparam logic [255:0] L4 = {8{32'h4444_dddd}};
  localparam logic [255:0] W1 = {8{32'hcafe_f00d}};
  localparam logic [255:0] W2 = {8{32'h0bad_beef}};

  logic exp_d [4];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst = 1'b1;
    imem_read = 0; imem_write = 0;
    imem_address = '0; imem_wdata = '0;
    dmem_read = 0; dmem_write = 0;
    dmem_address = '0; dmem_wdata = '0;
    mmem_rdata = '0; mmem_resp = 0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_mrd", mmem_read, 0);
    chk("rst_mwr", mmem_write, 0);
    chk("rst_iresp", imem_resp, 0);
    chk("rst_dresp", dmem_resp, 0);
    chk("rst_addr", mmem_address, 0);
    chk("rst_wdata", mmem_wdata, 0);
    chk("rst_irdata", imem_rdata, 0);
    chk("rst_drdata", dmem_rdata, 0);

    // Single I read, response 4 cycles after grant
    imem_read = 1; imem_address = 32'h60;
    #1;
    chk("i_grant_cycle_mrd", mmem_read, 0);
    tick;
    chk("i_mrd_t1", mmem_read, 1);
    chk("i_mwr_t1", mmem_write, 0);
    chk("i_addr", mmem_address, 32'h60);
    imem_address = 32'hdead_0000;
    tick;
    tick;
    chk("i_mrd_hold", mmem_read, 1);
    chk("i_addr_hold", mmem_address, 32'h60);
    tick;
    respond(L1);
    chk("i_resp", imem_resp, 1);
    chk("i_rdata", imem_rdata, L1);
    chk("i_dresp0", dmem_resp, 0);
    tick;
    imem_read = 0;
    release_resp;
    chk("i_mrd_drop", mmem_read, 0);
    chk("i_resp_pulse", imem_resp, 0);
    chk("i_rdata_hold", imem_rdata, L1);
    tick;

    // D write
    dmem_write = 1; dmem_address = 32'h8000_0020; dmem_wdata = W1;
    tick;
    chk("d_mwr", mmem_write, 1);
    chk("d_mrd", mmem_read, 0);
    chk("d_wdata", mmem_wdata, W1);
    chk("d_addr", mmem_address, 32'h8000_0020);
    dmem_wdata = W2;
    tick;
    chk("d_mwr_hold", mmem_write, 1);
    chk("d_wdata_hold", mmem_wdata, W1);
    respond(L3);
    chk("d_resp", dmem_resp, 1);
    chk("d_iresp0", imem_resp, 0);
    tick;
    dmem_write = 0;
    release_resp;
    chk("d_mwr_drop", mmem_write, 0);
    chk("d_resp_pulse", dmem_resp, 0);
    mmem_resp = 1; #1;
    chk("done_resp_ignored", dmem_resp, 0);
    mmem_resp = 0;
    tick;
    mmem_resp = 1; #1;
    chk("idle_resp_ign_d", dmem_resp, 0);
    chk("idle_resp_ign_i", imem_resp, 0);
    chk("idle_no_strobe", mmem_read | mmem_write, 0);
    mmem_resp = 0;
    tick;

    // Requester address change mid-serve
    dmem_read = 1; dmem_address = 32'h100;
    tick;
    dmem_address = 32'h200;
    tick;
    chk("chg_addr", mmem_address, 32'h100);
    chk("chg_mrd", mmem_read, 1);
    respond(L2);
    chk("chg_drdata", dmem_rdata, L2);
    tick;
    dmem_read = 0;
    release_resp;
    chk("chg_drdata_hold", dmem_rdata, L2);
    tick;

    // Read and write together act as write
    imem_read = 1; imem_write = 1;
    imem_address = 32'h40; imem_wdata = W2;
    tick;
    chk("rw_mwr", mmem_write, 1);
    chk("rw_mrd", mmem_read, 0);
    chk("rw_wdata", mmem_wdata, W2);
    respond(L3);
    chk("rw_resp", imem_resp, 1);
    tick;
    imem_read = 0; imem_write = 0;
    release_resp;
    tick;

    // Contention from a fresh reset
    rst = 1;
    tick;
    rst = 0;
    imem_read = 1; imem_address = 32'h1000;
    dmem_read = 1; dmem_address = 32'h2000;
    #1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("cont%0d_addr", k), mmem_address,
          exp_d[k] ? 32'h2000 : 32'h1000);
      respond(L4);
      chk($sformatf("cont%0d_dresp", k), dmem_resp, exp_d[k]);
      chk($sformatf("cont%0d_iresp", k), imem_resp, !exp_d[k]);
      tick;
      release_resp;
      tick;
    end
    imem_read = 0; dmem_read = 0;
    tick;

    // Reset two cycles into SERVE_I
    imem_read = 1; imem_address = 32'h300;
    tick;
    tick;
    rst = 1;
    respond(L3);
    chk("rst_abort_noresp", imem_resp, 0);
    tick;
    rst = 0;
    release_resp;
    chk("rst_abort_mrd", mmem_read, 0);
    chk("rst_abort_rdata", imem_rdata, 0);
    tick;
    chk("fresh_mrd", mmem_read, 1);
    chk("fresh_addr", mmem_address, 32'h300);
    respond(L4);
    chk("fresh_resp", imem_resp, 1);
    chk("fresh_rdata", imem_rdata, L4);

    // Held request: DONE, then re-grant two cycles after resp
    tick;
    release_resp;
    chk("b2b_done_mrd", mmem_read, 0);
    chk("b2b_done_resp", imem_resp, 0);
    tick;
    chk("b2b_idle_mrd", mmem_read, 0);
    tick;
    chk("b2b_regrant_mrd", mmem_read, 1);
    respond(L1);
    chk("b2b_resp", imem_resp, 1);
    tick;
    imem_read = 0;
    release_resp;
    tick;
    chk("end_idle", mmem_read | mmem_write, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
